// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcode/funct
// constants, datapath select codes and the control-word layout.
package cu_pkg;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_FETCH_WAIT, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_LW_READ, S_LW_WAIT, S_LW_WB,
    S_SW_WRITE, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_4       = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL = 2'd1;
  localparam logic [1:0] EXC_OVF     = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ab_write;
    logic       mdr_write;
    logic       aluout_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cu_output_decode.sv
// Combinational map from FSM state (plus opcode/funct/zero) to the control word.
module cu_output_decode
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH:      ctrl.iord = 1'b0;
      S_FETCH_WAIT: begin
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.ab_write     = 1'b1;
        ctrl.aluout_write = 1'b1;
        ctrl.alu_src_b    = SRCB_IMM_SH2;
        ctrl.alu_op       = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_B;
        ctrl.alu_op       = alu_of_funct(funct);
        ctrl.aluout_write = 1'b1;
      end
      S_WB_R: begin
        ctrl.reg_dest  = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a    = 1'b1;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.alu_op       = ALU_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_WB_I:      ctrl.reg_write = 1'b1;
      S_LW_READ:   ctrl.iord = 1'b1;
      S_LW_WAIT: begin
        ctrl.iord      = 1'b1;
        ctrl.mdr_write = 1'b1;
      end
      S_LW_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_SW_WRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        // Only Mealy output: take the branch on zero for beq, on ~zero for bne.
        ctrl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PCS_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS control FSM: state register, dispatch/trap logic and the
// sticky exception-cause register; outputs come from cu_output_decode.
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCwrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       MDRWrite,
  output logic       ALUOutWrite,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       halted,
  output logic [1:0] exc_cause
);

  state_t     state, state_nxt;
  logic       trap;
  logic [1:0] trap_cause;
  ctrl_t      ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RST;
      exc_cause <= EXC_NONE;
    end else begin
      state <= state_nxt;
      if (trap) exc_cause <= trap_cause;
    end
  end

  always_comb begin
    state_nxt  = state;
    trap       = 1'b0;
    trap_cause = EXC_NONE;
    case (state)
      S_RST:        state_nxt = S_FETCH;
      S_FETCH:      state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND)
              state_nxt = S_EXEC_R;
            else begin
              trap       = 1'b1;
              trap_cause = EXC_ILLEGAL;
            end
          end
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            trap       = 1'b1;
            trap_cause = EXC_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        // and cannot overflow; only add/sub trap.
        if (overflow && funct != FN_AND) begin
          trap       = 1'b1;
          trap_cause = EXC_OVF;
        end else state_nxt = S_WB_R;
      end
      S_EXEC_I: begin
        if (overflow) begin
          trap       = 1'b1;
          trap_cause = EXC_OVF;
        end else state_nxt = S_WB_I;
      end
      S_MEM_ADDR:   state_nxt = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
      S_LW_READ:    state_nxt = S_LW_WAIT;
      S_LW_WAIT:    state_nxt = S_LW_WB;
      S_WB_R, S_WB_I, S_LW_WB, S_SW_WRITE, S_BRANCH, S_JUMP:
                    state_nxt = S_FETCH;
      S_HALT:       state_nxt = S_HALT;
      default:      state_nxt = S_RST;
    endcase
    if (trap) state_nxt = S_HALT;
  end

  cu_output_decode u_dec (
    .state  (state),
    .opcode (opcode),
    .funct  (funct),
    .zero   (zero),
    .ctrl   (ctrl)
  );

  assign PCwrite     = ctrl.pc_write;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign ABWrite     = ctrl.ab_write;
  assign MDRWrite    = ctrl.mdr_write;
  assign ALUOutWrite = ctrl.aluout_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegDest     = ctrl.reg_dest;
  assign IorD        = ctrl.iord;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign halted      = ctrl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected control words are queued
// with each instruction and compared on the falling edge.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       PCwrite, MemWrite, IRWrite, RegWrite, ABWrite, MDRWrite, ALUOutWrite;
  logic       MemToReg, RegDest, IorD, ALUSrcA, halted;
  logic [1:0] ALUSrcB, PCSource, exc_cause;
  logic [2:0] ALUOp;

  int checks = 0;
  int failures = 0;

  logic [20:0] exp_q[$];
  string       tag_q[$];
  logic [20:0] obs;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .PCwrite(PCwrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ABWrite(ABWrite), .MDRWrite(MDRWrite),
    .ALUOutWrite(ALUOutWrite), .MemToReg(MemToReg), .RegDest(RegDest), .IorD(IorD),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .halted(halted), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  assign obs = {PCwrite, MemWrite, IRWrite, RegWrite, ABWrite, MDRWrite, ALUOutWrite,
                MemToReg, RegDest, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, exc_cause};

  function automatic logic [20:0] mk(
    input logic pcw, mw, irw, rw, abw, mdrw, aow, m2r, rd, iord, sa,
    input logic [1:0] sb, input logic [2:0] op, input logic [1:0] ps,
    input logic h, input logic [1:0] ex);
    return {pcw, mw, irw, rw, abw, mdrw, aow, m2r, rd, iord, sa, sb, op, ps, h, ex};
  endfunction

  localparam logic [2:0] A_ADD = 3'b001, A_SUB = 3'b010, A_AND = 3'b011;

  function automatic logic [20:0] w_fw();   return mk(1,0,1,0,0,0,0,0,0,0,0,2'd1,A_ADD,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_dec();  return mk(0,0,0,0,1,0,1,0,0,0,0,2'd3,A_ADD,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_exr(input logic [2:0] op);
    return mk(0,0,0,0,0,0,1,0,0,0,1,2'd0,op,2'd0,0,2'd0);
  endfunction
  function automatic logic [20:0] w_wbr();  return mk(0,0,0,1,0,0,0,0,1,0,0,2'd0,3'd0,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_exi();  return mk(0,0,0,0,0,0,1,0,0,0,1,2'd2,A_ADD,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_wbi();  return mk(0,0,0,1,0,0,0,0,0,0,0,2'd0,3'd0,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_lwr();  return mk(0,0,0,0,0,0,0,0,0,1,0,2'd0,3'd0,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_lww();  return mk(0,0,0,0,0,1,0,0,0,1,0,2'd0,3'd0,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_lwwb(); return mk(0,0,0,1,0,0,0,1,0,0,0,2'd0,3'd0,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_sw();   return mk(0,1,0,0,0,0,0,0,0,1,0,2'd0,3'd0,2'd0,0,2'd0); endfunction
  function automatic logic [20:0] w_br(input logic pcw);
    return mk(pcw,0,0,0,0,0,0,0,0,0,1,2'd0,A_SUB,2'd1,0,2'd0);
  endfunction
  function automatic logic [20:0] w_j();    return mk(1,0,0,0,0,0,0,0,0,0,0,2'd0,3'd0,2'd2,0,2'd0); endfunction
  function automatic logic [20:0] w_halt(input logic [1:0] ex);
    return mk(0,0,0,0,0,0,0,0,0,0,0,2'd0,3'd0,2'd0,1,ex);
  endfunction

  task automatic push(input logic [20:0] w, input string t);
    exp_q.push_back(w);
    tag_q.push_back(t);
  endtask

  task automatic check_now();
    logic [20:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      check_now();
      step();
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    opcode = op; funct = fn; zero = z; overflow = ov;
  endtask

  task automatic push_front_end(input string t);
    push('0, {t, "_fetch"});
    push(w_fw(), {t, "_fetch_wait"});
    push(w_dec(), {t, "_decode"});
  endtask

  // Reset from the falling edge, check async clear, release, expect one RST cycle.
  task automatic do_reset(input string t);
    reset = 1'b1;
    #1;
    push('0, {t, "_in_reset"});
    check_now();
    @(negedge clk);
    reset = 1'b0;
    push('0, {t, "_rst_state"});
  endtask

  initial begin
    reset = 1'b1;
    drive(6'h00, 6'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    push('0, "por_reset");
    check_now();
    reset = 1'b0;
    push('0, "por_rst_state");

    // add, sub, and (and ignores overflow)
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    push_front_end("add"); push(w_exr(A_ADD), "add_exec"); push(w_wbr(), "add_wb");
    drain();
    drive(6'h00, 6'h22, 1'b1, 1'b0);
    push_front_end("sub"); push(w_exr(A_SUB), "sub_exec"); push(w_wbr(), "sub_wb");
    drain();
    drive(6'h00, 6'h24, 1'b0, 1'b1);
    push_front_end("and"); push(w_exr(A_AND), "and_exec"); push(w_wbr(), "and_wb");
    drain();

    // addi, lw, sw; overflow set outside EXEC_I must be ignored by lw/sw
    drive(6'h08, 6'h00, 1'b0, 1'b0);
    push_front_end("addi"); push(w_exi(), "addi_exec"); push(w_wbi(), "addi_wb");
    drain();
    drive(6'h23, 6'h11, 1'b0, 1'b1);
    push_front_end("lw"); push(w_exi(), "lw_addr"); push(w_lwr(), "lw_read");
    push(w_lww(), "lw_wait"); push(w_lwwb(), "lw_wb");
    drain();
    drive(6'h2B, 6'h00, 1'b0, 1'b1);
    push_front_end("sw"); push(w_exi(), "sw_addr"); push(w_sw(), "sw_write");
    drain();

    // branches and jump
    drive(6'h04, 6'h00, 1'b1, 1'b0);
    push_front_end("beq_t"); push(w_br(1'b1), "beq_taken"); drain();
    drive(6'h04, 6'h00, 1'b0, 1'b0);
    push_front_end("beq_nt"); push(w_br(1'b0), "beq_not_taken"); drain();
    drive(6'h05, 6'h00, 1'b1, 1'b0);
    push_front_end("bne_nt"); push(w_br(1'b0), "bne_not_taken"); drain();
    drive(6'h05, 6'h00, 1'b0, 1'b0);
    push_front_end("bne_t"); push(w_br(1'b1), "bne_taken"); drain();
    drive(6'h02, 6'h00, 1'b0, 1'b0);
    push_front_end("j"); push(w_j(), "jump"); drain();

    // reset while in LW_WAIT
    drive(6'h23, 6'h00, 1'b0, 1'b0);
    push_front_end("lw2"); push(w_exi(), "lw2_addr"); push(w_lwr(), "lw2_read");
    drain();
    push(w_lww(), "lw2_wait");
    check_now();
    do_reset("mid_lw");
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    push_front_end("add2"); push(w_exr(A_ADD), "add2_exec"); push(w_wbr(), "add2_wb");
    drain();

    // addi overflow trap, stays halted for 100 cycles
    drive(6'h08, 6'h00, 1'b0, 1'b1);
    push_front_end("addi_ovf"); push(w_exi(), "addi_ovf_exec");
    for (int i = 0; i < 100; i++) push(w_halt(2'd2), "addi_ovf_halt");
    drain();
    do_reset("after_ovf");

    // add overflow trap in EXEC_R
    drive(6'h00, 6'h20, 1'b0, 1'b1);
    push_front_end("add_ovf"); push(w_exr(A_ADD), "add_ovf_exec");
    for (int i = 0; i < 4; i++) push(w_halt(2'd2), "add_ovf_halt");
    drain();
    do_reset("after_add_ovf");

    // illegal opcode, then illegal funct
    drive(6'h3F, 6'h00, 1'b0, 1'b0);
    push_front_end("ill_op");
    for (int i = 0; i < 4; i++) push(w_halt(2'd1), "ill_op_halt");
    drain();
    do_reset("after_ill_op");
    drive(6'h00, 6'h2A, 1'b0, 1'b0);
    push_front_end("ill_fn");
    for (int i = 0; i < 4; i++) push(w_halt(2'd1), "ill_fn_halt");
    drain();
    do_reset("final");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
